// File: rtl/seg_s2p_rx.sv
// Receive side of the serial seven-segment link: resynchronises clock/data/enable/clear
// and rebuilds WIDTH-bit frames, flagging good frames and malformed ones with pulses.
module seg_s2p_rx #(
    parameter int WIDTH       = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seg_clk,
    input  logic             seg_sout,
    input  logic             SEG_PEN,
    input  logic             seg_clrn,
    output logic [WIDTH-1:0] p_data,
    output logic             frame_valid,
    output logic             frame_err,
    output logic             busy,
    output logic [15:0]      frame_cnt
);
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] pen_sync_q, pen_sync_d;
    logic [SYNC_STAGES-1:0] clrn_sync_q, clrn_sync_d;
    logic [SYNC_STAGES-1:0] sout_sync_q, sout_sync_d;
    logic sclk_hist_q, sclk_hist_d;
    logic pen_hist_q, pen_hist_d;
    logic ev_sclk_rise_q, ev_sclk_rise_d;
    logic ev_pen_rise_q, ev_pen_rise_d;
    logic ev_pen_fall_q, ev_pen_fall_d;
    logic ev_clr_q, ev_clr_d;
    logic ev_sout_q, ev_sout_d;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] p_data_q, p_data_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    // Edges are detected after the last sync stage and registered once more, so the
    // serial data bit travels alongside its clock edge through an identical pipeline.
    always_comb begin
        sclk_sync_d    = {sclk_sync_q[SYNC_STAGES-2:0], seg_clk};
        pen_sync_d     = {pen_sync_q[SYNC_STAGES-2:0], SEG_PEN};
        clrn_sync_d    = {clrn_sync_q[SYNC_STAGES-2:0], seg_clrn};
        sout_sync_d    = {sout_sync_q[SYNC_STAGES-2:0], seg_sout};
        sclk_hist_d    = sclk_sync_q[SYNC_STAGES-1];
        pen_hist_d     = pen_sync_q[SYNC_STAGES-1];
        ev_sclk_rise_d = sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q;
        ev_pen_rise_d  = pen_sync_q[SYNC_STAGES-1] & ~pen_hist_q;
        ev_pen_fall_d  = ~pen_sync_q[SYNC_STAGES-1] & pen_hist_q;
        ev_clr_d       = ~clrn_sync_q[SYNC_STAGES-1];
        ev_sout_d      = sout_sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        cnt_d         = cnt_q;
        p_data_d      = p_data_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (ev_pen_fall_q) begin
                    state_d = SHIFT;
                    sr_d    = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // Clear beats a coincident shift; the shift lands before the length check.
                if (ev_clr_q) begin
                    sr_d  = '0;
                    cnt_d = '0;
                end else if (ev_sclk_rise_q) begin
                    sr_d  = {sr_q[WIDTH-2:0], ev_sout_q};
                    cnt_d = (cnt_q == CW'(WIDTH + 1)) ? cnt_q : cnt_q + 1'b1;
                end
                if (ev_pen_rise_q) begin
                    state_d = IDLE;
                    if (cnt_d == CW'(WIDTH)) begin
                        p_data_d      = sr_d;
                        frame_valid_d = 1'b1;
                        frame_cnt_d   = frame_cnt_q + 16'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q    <= '1;
            pen_sync_q     <= '1;
            clrn_sync_q    <= '1;
            sout_sync_q    <= '0;
            sclk_hist_q    <= 1'b1;
            pen_hist_q     <= 1'b1;
            ev_sclk_rise_q <= 1'b0;
            ev_pen_rise_q  <= 1'b0;
            ev_pen_fall_q  <= 1'b0;
            ev_clr_q       <= 1'b0;
            ev_sout_q      <= 1'b0;
            state_q        <= IDLE;
            sr_q           <= '0;
            cnt_q          <= '0;
            p_data_q       <= '0;
            frame_valid_q  <= 1'b0;
            frame_err_q    <= 1'b0;
            busy_q         <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            sclk_sync_q    <= sclk_sync_d;
            pen_sync_q     <= pen_sync_d;
            clrn_sync_q    <= clrn_sync_d;
            sout_sync_q    <= sout_sync_d;
            sclk_hist_q    <= sclk_hist_d;
            pen_hist_q     <= pen_hist_d;
            ev_sclk_rise_q <= ev_sclk_rise_d;
            ev_pen_rise_q  <= ev_pen_rise_d;
            ev_pen_fall_q  <= ev_pen_fall_d;
            ev_clr_q       <= ev_clr_d;
            ev_sout_q      <= ev_sout_d;
            state_q        <= state_d;
            sr_q           <= sr_d;
            cnt_q          <= cnt_d;
            p_data_q       <= p_data_d;
            frame_valid_q  <= frame_valid_d;
            frame_err_q    <= frame_err_d;
            busy_q         <= busy_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    assign p_data      = p_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_seg_s2p_rx.sv
// Scoreboard bench for seg_s2p_rx: stimulus pushes expected frame outcomes, a negedge
// monitor pops one per frame_valid/frame_err pulse and checks data, count and latency.
module tb_seg_s2p_rx;
    logic        clk;
    logic        rst;
    logic        seg_clk;
    logic        seg_sout;
    logic        SEG_PEN;
    logic        seg_clrn;
    logic [63:0] p_data;
    logic        frame_valid;
    logic        frame_err;
    logic        busy;
    logic [15:0] frame_cnt;

    typedef struct {
        bit          is_err;
        logic [63:0] data;
        logic [15:0] cnt;
        int          rise_cycle;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;
    logic [63:0] model_pdata = '0;
    logic [15:0] model_cnt   = '0;

    seg_s2p_rx #(.WIDTH(64), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_clk    (seg_clk),
        .seg_sout   (seg_sout),
        .SEG_PEN    (SEG_PEN),
        .seg_clrn   (seg_clrn),
        .p_data     (p_data),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    // Each strobe must match the oldest outstanding expectation exactly.
    always @(negedge clk) begin
        if (!rst && (frame_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pulse valid=%0b err=%0b", frame_valid, frame_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("pulse_kind_valid", 64'(frame_valid), 64'(!e.is_err));
                checkOutput("pulse_kind_err", 64'(frame_err), 64'(e.is_err));
                checkOutput("p_data", p_data, e.data);
                checkOutput("frame_cnt", 64'(frame_cnt), 64'(e.cnt));
                checkOutput("latency", 64'(cycle - e.rise_cycle), 64'd4);
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic startFrame();
        SEG_PEN = 1'b0;
        waitCycles(5);
        checkOutput("busy_in_frame", 64'(busy), 64'd1);
    endtask

    task automatic shiftBit(input logic b);
        seg_clk  = 1'b0;
        seg_sout = b;
        waitCycles(4);
        seg_clk = 1'b1;
        waitCycles(4);
    endtask

    task automatic endFrame(input bit good, input logic [63:0] data);
        exp_t e;
        SEG_PEN = 1'b1;
        if (good) begin
            model_pdata = data;
            model_cnt   = model_cnt + 16'd1;
        end
        e.is_err     = !good;
        e.data       = model_pdata;
        e.cnt        = model_cnt;
        e.rise_cycle = cycle;
        exp_q.push_back(e);
        waitCycles(12);
        checkOutput("busy_after_frame", 64'(busy), 64'd0);
    endtask

    // Sends nbits of data MSB first; bits past 64 are zeros. With merge_last the final
    // shift clock rise and the SEG_PEN rise hit the pins in the same cycle.
    task automatic applyStimulus(input logic [63:0] data, input int nbits, input bit merge_last);
        logic b;
        startFrame();
        for (int i = 0; i < nbits; i++) begin
            if (i < 64) b = data[63-i];
            else b = 1'b0;
            if (merge_last && i == nbits - 1) begin
                seg_clk  = 1'b0;
                seg_sout = b;
                waitCycles(4);
                seg_clk = 1'b1;
            end else begin
                shiftBit(b);
            end
        end
        endFrame(nbits == 64, data);
    endtask

    initial begin
        logic [63:0] clr_pattern;
        rst      = 1'b1;
        seg_clk  = 1'b0;
        seg_sout = 1'b0;
        SEG_PEN  = 1'b1;
        seg_clrn = 1'b1;
        waitCycles(3);
        checkOutput("reset_p_data", p_data, 64'd0);
        checkOutput("reset_valid", 64'(frame_valid), 64'd0);
        checkOutput("reset_err", 64'(frame_err), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_cnt", 64'(frame_cnt), 64'd0);
        rst = 1'b0;
        waitCycles(5);

        $display("[TB] good frame");
        applyStimulus(64'h0123456789ABCDEF, 64, 1'b0);
        $display("[TB] short and long frames");
        applyStimulus(64'hFEDCBA9876543210, 63, 1'b0);
        applyStimulus(64'hFEDCBA9876543210, 65, 1'b0);

        $display("[TB] clear mid-frame");
        clr_pattern = 64'hFFFF0000AAAA5555;
        startFrame();
        for (int i = 0; i < 20; i++) shiftBit(i[0]);
        seg_clk  = 1'b0;
        seg_clrn = 1'b0;
        waitCycles(5);
        seg_clrn = 1'b1;
        waitCycles(5);
        for (int i = 0; i < 64; i++) shiftBit(clr_pattern[63-i]);
        endFrame(1'b1, clr_pattern);

        $display("[TB] idle shift clock");
        for (int i = 0; i < 10; i++) begin
            seg_sout = i[0];
            seg_clk  = 1'b0;
            waitCycles(4);
            seg_clk = 1'b1;
            waitCycles(4);
        end
        checkOutput("idle_p_data", p_data, model_pdata);
        checkOutput("idle_cnt", 64'(frame_cnt), 64'(model_cnt));
        checkOutput("idle_busy", 64'(busy), 64'd0);

        $display("[TB] last shift coincident with enable rise");
        applyStimulus(64'hDEADBEEFCAFEF00D, 64, 1'b1);

        $display("[TB] reset mid-frame");
        startFrame();
        for (int i = 0; i < 30; i++) shiftBit(1'b1);
        rst = 1'b1;
        waitCycles(2);
        seg_clk  = 1'b0;
        SEG_PEN  = 1'b1;
        seg_clrn = 1'b1;
        waitCycles(3);
        rst = 1'b0;
        model_pdata = '0;
        model_cnt   = '0;
        waitCycles(8);
        checkOutput("post_reset_p_data", p_data, 64'd0);
        checkOutput("post_reset_cnt", 64'(frame_cnt), 64'd0);
        checkOutput("post_reset_busy", 64'(busy), 64'd0);
        applyStimulus(64'h0000000000000001, 64, 1'b0);
        checkOutput("after_abort_p_data", p_data, 64'h0000000000000001);
        checkOutput("after_abort_cnt", 64'(frame_cnt), 64'd1);

        $display("[TB] frame counter wrap");
        force dut.frame_cnt_q = 16'hFFFF;
        waitCycles(1);
        release dut.frame_cnt_q;
        model_cnt = 16'hFFFF;
        waitCycles(2);
        checkOutput("preload_cnt", 64'(frame_cnt), 64'hFFFF);
        applyStimulus(64'h5A5A5A5A12345678, 64, 1'b0);
        checkOutput("wrap_cnt", 64'(frame_cnt), 64'd0);

        for (int t = 0; t < 200 && exp_q.size() != 0; t++) waitCycles(1);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_s2p_rx.md
Name: seg_s2p_rx

Overview:
- Receive end of the serial seven-segment display link: deserialises the clock/data/enable/clear stream produced by the display serialiser back into a parallel frame.
- Oversamples the four link signals on the system clock and rebuilds the WIDTH-bit frame. Each completed frame is presented with a one-cycle valid strobe.
- Used as a loopback monitor in the display path and as the checker model in display-path benches.

Parameters:
WIDTH, 64, frame length in bits
SYNC_STAGES, 2, synchroniser depth on each link input (min 2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
seg_clk  input  1  link shift clock, asynchronous to clk
seg_sout  input  1  link serial data, MSB first
SEG_PEN  input  1  link enable: low while shifting, rising edge ends frame
seg_clrn  input  1  link clear, active low
p_data  output  WIDTH  last good frame, bit WIDTH-1 = first bit received
frame_valid  output  1  one-cycle pulse when p_data updates
frame_err  output  1  one-cycle pulse on a malformed frame
busy  output  1  high while in SHIFT state
frame_cnt  output  16  count of good frames, wraps 0xFFFF->0

Behaviour:
- Reset (async, rst=1):
  - p_data=0, frame_valid=0, frame_err=0, busy=0, frame_cnt=0.
  - Shift register and bit count cleared; state=IDLE.
  - Synchroniser and edge-history flops are set to 1 for seg_clk/SEG_PEN/seg_clrn and 0 for seg_sout, so no false edge is seen at reset release.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops, then one history flop for edge detection.
  - sclk_rise = synced seg_clk 0->1; pen_fall / pen_rise likewise on SEG_PEN; clr = synced seg_clrn==0.
  - Link requirement: seg_clk high and low phases and SEG_PEN pulses each last at least SYNC_STAGES+1 clk cycles. Narrower pulses are not guaranteed to be seen.
- State machine:
  - IDLE:
    - sclk_rise ignored.
    - pen_fall -> SHIFT, bit count=0, shift register=0.
    - pen_rise without a frame in progress is ignored.
  - SHIFT:
    - sclk_rise: shift register <= {sr[WIDTH-2:0], seg_sout_synced}; count increments, saturating at WIDTH+1.
    - clr: shift register and count cleared; stays in SHIFT.
    - pen_rise: frame ends, go to IDLE.
      - If final count == WIDTH: p_data <= shift register, frame_valid=1 for one cycle, frame_cnt+1.
      - Otherwise: frame_err=1 for one cycle; p_data and frame_cnt unchanged.
- Simultaneous events:
  - sclk_rise and pen_rise in the same cycle: the shift is applied first, and the length check uses the post-shift count and register.
  - clr together with sclk_rise: clear wins, the bit is discarded.
  - clr together with pen_rise: clear applies, count=0, so frame_err is raised.
- Latency: frame_valid asserts SYNC_STAGES+2 clk cycles after the SEG_PEN rising edge at the pin.
- Overflow: more than WIDTH sclk edges saturates the count at WIDTH+1, giving frame_err at pen_rise.
- busy = (state==SHIFT), registered.
- Reset mid-frame: partial frame abandoned. frame_valid and frame_err stay 0 on reset release.

Test Plan:
- Reset then send 64 bits of 0x0123456789ABCDEF MSB first, 4-cycle seg_clk half-periods, then SEG_PEN rise -> p_data=0x0123456789ABCDEF, a single frame_valid pulse exactly 4 cycles after the pin edge, frame_cnt=1, busy low afterwards.
- Send 63 bits then pen rise -> frame_err pulse, p_data holds its previous value, frame_cnt unchanged. Repeat with 65 bits -> frame_err.
- Send 20 bits, pulse seg_clrn low, then send 64 bits of 0xFFFF0000AAAA5555 -> frame_valid with p_data=0xFFFF0000AAAA5555.
- Assert rst after 30 bits, release, then send a full frame 0x1 -> no pulse caused by the aborted frame, p_data=0x0000000000000001, frame_cnt=1.
- Force frame_cnt to 0xFFFF by sending 65535 back-to-back good frames (or preload in sim), then one more good frame -> frame_cnt wraps to 0x0000.
- seg_clk toggles while SEG_PEN stays high (IDLE) -> p_data, frame_cnt and strobes unchanged; 64th sclk rise in the same clk cycle as pen_rise -> frame accepted with the final bit included.
